// File: rtl/tile_map_engine_if.sv
// rtl/tile_map_engine_if.sv - host cell-write port of the tile map engine
interface tile_map_engine_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_din;
    logic              host_ready;

    modport master (output host_we, host_addr, host_din, input host_ready);
    modport slave  (input host_we, host_addr, host_din, output host_ready);
endinterface

// File: rtl/tile_map_engine.sv
// rtl/tile_map_engine.sv - tile RAM with beam-driven video read, frame-paced sweep and host write port
module tile_map_engine #(
    parameter int COL_BITS  = 5,
    parameter int ROW_BITS  = 5,
    parameter int CELL_BITS = 3,
    parameter int DATA_W    = 8,
    parameter int DIGIT_MOD = 10,
    parameter int FRAME_DIV = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 display_on,
    input  logic                 vsync,
    input  logic [1:0]           mode,
    tile_map_engine_if.slave     host,
    output logic [DATA_W-1:0]    tile_code,
    output logic [CELL_BITS-1:0] cell_xofs,
    output logic [CELL_BITS-1:0] cell_yofs,
    output logic                 pix_valid,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 overrun
);
    localparam int ADDR_W = COL_BITS + ROW_BITS;
    localparam int CELLS  = 1 << ADDR_W;
    localparam int MAP_W  = (1 << COL_BITS) << CELL_BITS;
    localparam int MAP_H  = (1 << ROW_BITS) << CELL_BITS;
    localparam int FD_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [ADDR_W-1:0] LAST  = '1;
    localparam logic [DATA_W:0]   MOD_V = (DATA_W+1)'(DIGIT_MOD);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [1:0]        sweep_mode, mode_n;
    logic              vsync_d, trigger;
    logic [FD_W-1:0]   frame_cnt;
    logic [15:0]       lfsr;

    logic [DATA_W-1:0] mem [0:CELLS-1];
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] rd_b, din_b, next_val;
    logic              we_b;
    logic [DATA_W:0]   inc_w;
    logic [CELL_BITS-1:0] xofs1, yofs1;
    logic              pv1;

    wire rise = vsync & ~vsync_d;

    // Frame pacing: trigger fires one cycle after the FRAME_DIV-th vsync rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
            trigger   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            trigger <= 1'b0;
            if (rise) begin
                if (frame_cnt == FD_W'(FRAME_DIV - 1)) begin
                    frame_cnt <= '0;
                    trigger   <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'h0001;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Video path stage 1: cell address and offsets; stage 2 is the RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_a <= '0;
            xofs1  <= '0;
            yofs1  <= '0;
            pv1    <= 1'b0;
        end else begin
            addr_a <= {vpos[CELL_BITS+ROW_BITS-1:CELL_BITS], hpos[CELL_BITS+COL_BITS-1:CELL_BITS]};
            xofs1  <= hpos[CELL_BITS-1:0];
            yofs1  <= vpos[CELL_BITS-1:0];
            pv1    <= display_on && ({1'b0, hpos} < 11'(MAP_W)) && ({1'b0, vpos} < 11'(MAP_H));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_code <= '0;
            cell_xofs <= '0;
            cell_yofs <= '0;
            pix_valid <= 1'b0;
        end else begin
            tile_code <= mem[addr_a];
            cell_xofs <= xofs1;
            cell_yofs <= yofs1;
            pix_valid <= pv1;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        rd_b <= mem[addr_b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            sweep_mode <= 2'd0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            sweep_mode <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        mode_n  = sweep_mode;
        case (state)
            IDLE: if (trigger && mode != 2'd0) begin
                mode_n  = mode;
                ptr_n   = '0;
                state_n = READ;
            end
            READ: if (!display_on) state_n = WRITE;
            WRITE: begin
                if (ptr == LAST) begin
                    state_n = IDLE;
                end else begin
                    ptr_n   = ptr + 1'b1;
                    state_n = READ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Increment compares in DATA_W+1 bits so stale codes >= DIGIT_MOD also wrap to 0.
    always_comb begin
        inc_w = {1'b0, rd_b} + 1'b1;
        case (sweep_mode)
            2'd1:    next_val = (inc_w >= MOD_V) ? '0 : inc_w[DATA_W-1:0];
            2'd2:    next_val = lfsr[DATA_W-1:0];
            default: next_val = '0;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        sweep_done = (state == WRITE) && (ptr == LAST);
        overrun    = trigger && (state != IDLE);
        we_b       = 1'b0;
        addr_b     = ptr;
        din_b      = next_val;
        if (state == WRITE) begin
            we_b = 1'b1;
        end else if (state == IDLE && host.host_we) begin
            we_b   = 1'b1;
            addr_b = host.host_addr;
            din_b  = host.host_din;
        end
    end

    assign host.host_ready = (state == IDLE);
endmodule

// File: tb/tb_tile_map_engine.sv
// tb/tb_tile_map_engine.sv - directed scoreboard bench for tile_map_engine
module tb_tile_map_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hpos = '0, vpos = '0;
    logic       display_on = 1'b0, vsync = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] tile_code;
    logic [2:0] cell_xofs, cell_yofs;
    logic       pix_valid, busy, sweep_done, overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb[$];
    logic [15:0] m_lfsr;

    tile_map_engine_if #(.ADDR_W(10), .DATA_W(8)) hif ();

    tile_map_engine dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .vsync(vsync), .mode(mode), .host(hif),
        .tile_code(tile_code), .cell_xofs(cell_xofs), .cell_yofs(cell_yofs),
        .pix_valid(pix_valid), .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'h0001;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int addr, input logic [7:0] din);
        hif.host_we = 1'b1;
        hif.host_addr = 10'(addr);
        hif.host_din = din;
        tick(1);
        hif.host_we = 1'b0;
    endtask

    task automatic vsync_rises(input int n);
        repeat (n) begin
            vsync = 1'b1; tick(1);
            vsync = 1'b0; tick(1);
        end
    endtask

    task automatic read_cell(input string tag, input int row, input int col, input logic [7:0] exp);
        hpos = 10'(col * 8);
        vpos = 10'(row * 8);
        display_on = 1'b1;
        sb.push_back(32'(exp));
        tick(2);
        check(tag, 32'(tile_code), sb.pop_front());
        display_on = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check("sweep_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int bc, ovr, done;
        bit seen;
        logic [7:0] r0, r1;

        hif.host_we = 1'b0;
        hif.host_addr = '0;
        hif.host_din = '0;

        // Reset state
        tick(2);
        check("rst_tile_code", 32'(tile_code), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_host_ready", 32'(hif.host_ready), 32'd1);
        reset = 1'b0;
        tick(1);

        // Host write and beam lookup
        host_write(3 * 32 + 5, 8'h07);
        hpos = 10'd43; vpos = 10'd29; display_on = 1'b1;
        sb.push_back(32'h07);
        tick(2);
        check("host_tile", 32'(tile_code), sb.pop_front());
        check("host_pix_valid", 32'(pix_valid), 32'd1);
        check("xofs", 32'(cell_xofs), 32'd3);
        check("yofs", 32'(cell_yofs), 32'd5);
        read_cell("host_tile_origin", 3, 5, 8'h07);
        hpos = 10'd256; vpos = 10'd24; display_on = 1'b1;
        tick(2);
        check("offmap_pix_valid", 32'(pix_valid), 32'd0);
        display_on = 1'b0;

        // Increment sweep with pause, overrun and dropped host write
        host_write(0, 8'd9);
        host_write(1, 8'd4);
        host_write(2, 8'd200);
        mode = 2'd1;
        vsync_rises(15);
        tick(3);
        check("no_sweep_15", 32'(busy), 32'd0);
        bc = 0; ovr = 0; done = 0; seen = 0;
        vsync = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (busy) begin seen = 1; bc++; end
            else if (seen) break;
            if (overrun) ovr++;
            if (sweep_done) done++;
            vsync = (bc >= 1000 && bc < 1032 && (bc % 2) == 0);
            display_on = (bc >= 101 && bc <= 600);
            if (bc >= 1500 && bc < 1504) begin
                check("host_ready_busy", 32'(hif.host_ready), 32'd0);
                hif.host_we = 1'b1;
                hif.host_addr = 10'(3 * 32 + 5);
                hif.host_din = 8'hAA;
            end else begin
                hif.host_we = 1'b0;
            end
        end
        vsync = 1'b0; display_on = 1'b0; hif.host_we = 1'b0;
        check("inc_sweep_end", 32'(busy), 32'd0);
        check("inc_busy_cycles", 32'(bc), 32'd2548);
        check("inc_overrun_count", 32'(ovr), 32'd1);
        check("inc_done_count", 32'(done), 32'd1);
        check("idle_host_ready", 32'(hif.host_ready), 32'd1);
        read_cell("inc_wrap_9", 0, 0, 8'd0);
        read_cell("inc_4", 0, 1, 8'd5);
        read_cell("inc_over_mod", 0, 2, 8'd0);
        read_cell("inc_7_no_host", 3, 5, 8'd8);

        // Random sweep
        mode = 2'd2;
        vsync_rises(16);
        check("rnd_busy", 32'(busy), 32'd1);
        tick(1);
        r0 = m_lfsr[7:0];
        tick(2);
        r1 = m_lfsr[7:0];
        wait_idle(2100);
        read_cell("rnd_cell0", 0, 0, r0);
        read_cell("rnd_cell1", 0, 1, r1);

        // Clear sweep interrupted by reset
        mode = 2'd3;
        host_write(10, 8'h66);
        host_write(900, 8'h55);
        vsync_rises(16);
        tick(200);
        check("clr_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_host_ready", 32'(hif.host_ready), 32'd1);
        check("mid_rst_tile_code", 32'(tile_code), 32'd0);
        check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("mid_rst_xofs", 32'(cell_xofs), 32'd0);
        check("mid_rst_sweep_done", 32'(sweep_done), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        read_cell("rst_kept_cleared", 0, 10, 8'h00);
        read_cell("rst_kept_untouched", 28, 4, 8'h55);

        // Full clear sweep, then read back the whole map
        vsync_rises(16);
        check("clr_busy", 32'(busy), 32'd1);
        wait_idle(2100);
        display_on = 1'b1;
        for (int i = 0; i <= 1024; i++) begin
            if (i < 1024) begin
                hpos = 10'((i % 32) * 8);
                vpos = 10'((i / 32) * 8);
                sb.push_back(32'd0);
            end
            tick(1);
            if (i >= 1) check("clear_all", 32'(tile_code), sb.pop_front());
        end
        display_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
